// File: rtl/viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_frame_ctrl
//
// Frame scheduler in front of the single Viterbi decoder core. Requesters
// offer one code word each over valid/ready. A round-robin arbiter picks the
// next word. The word and the shared trellis table are loaded into the core,
// and the core is restarted through its active-low reset. The block then
// waits for the core's finish flag, with a timeout, and returns the decoded
// word tagged with the requester id over a valid/ready response port.
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   req_valid/code  : NREQ requesters, word i at req_code[i*LENIN +: LENIN]
//   req_ready       : one-hot grant, combinational, only in IDLE
//   cfg_states      : trellis expected-parity table, captured at grant
//   core_*          : registered drive to the core / finish + result back
//   rsp_*           : response channel (data, id, timeout flag)
//   busy            : high in every state except IDLE
//   frames_done     : accepted responses, wraps
//   err_count       : accepted timed-out responses, saturates
// ---------------------------------------------------------------------------
module viterbi_frame_ctrl #(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int LENIN   = 10,
    parameter int LENOUT  = 5,
    parameter int STW     = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*LENIN-1:0]   req_code,
    output logic [NREQ-1:0]         req_ready,
    input  logic [STW-1:0]          cfg_states,
    output logic                    core_rst_n,
    output logic [LENIN-1:0]        core_codein,
    output logic [STW-1:0]          core_states,
    input  logic [LENOUT-1:0]       core_codeout,
    input  logic                    core_finish,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LENOUT-1:0]       rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [15:0]             frames_done,
    output logic [7:0]              err_count
);

    // state | meaning
    // IDLE  | core held in reset, arbitrate and capture the winning word
    // LOAD  | one cycle of core reset with new word/table stable
    // RUN   | core running, wait for finish or timeout
    // RESP  | core held in reset, response offered until accepted
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

    state_t              state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [CNTW-1:0]     to_cnt_q;
    logic                core_rst_n_q;
    logic [LENIN-1:0]    core_codein_q;
    logic [STW-1:0]      core_states_q;
    logic                rsp_valid_q;
    logic [LENOUT-1:0]   rsp_data_q;
    logic [IDW-1:0]      rsp_id_q;
    logic                rsp_err_q;
    logic [15:0]         frames_q;
    logic [7:0]          err_cnt_q;

    logic [CNTW-1:0]     to_cnt_d;
    logic [15:0]         frames_d;
    logic [7:0]          err_cnt_d;

    logic                gnt_found;
    logic [IDW-1:0]      gnt_idx;
    logic [IDW-1:0]      cand;
    logic [LENIN-1:0]    gnt_word;
    logic                to_last;
    logic                rsp_accept;

    // Round-robin search starting just above the last winner, so the last
    // winner has the lowest priority. A requester that drops valid while
    // waiting keeps its place because only a grant moves the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_word = req_code[gnt_idx*LENIN +: LENIN];

    // Grant is gated by rst so that no requester sees ready during reset.
    always_comb begin
        req_ready = '0;
        if (rst && (state_q == S_IDLE) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign to_last    = (to_cnt_q == TO_LAST);
    assign rsp_accept = rsp_valid_q & rsp_ready;
    assign to_cnt_d   = to_cnt_q + CNTW'(1);
    assign frames_d   = frames_q + 16'd1;
    assign err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= IDW'(NREQ - 1);
            to_cnt_q      <= '0;
            core_rst_n_q  <= 1'b0;
            core_codein_q <= '0;
            core_states_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_id_q      <= '0;
            rsp_err_q     <= 1'b0;
            frames_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    core_rst_n_q <= 1'b0;
                    if (gnt_found) begin
                        core_codein_q <= gnt_word;
                        core_states_q <= cfg_states;
                        rsp_id_q      <= gnt_idx;
                        rr_ptr_q      <= gnt_idx;
                        state_q       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Core reset is released on the edge that enters RUN.
                    to_cnt_q     <= '0;
                    core_rst_n_q <= 1'b1;
                    state_q      <= S_RUN;
                end
                S_RUN: begin
                    // Finish is checked first so it wins over a coincident timeout.
                    if (core_finish) begin
                        rsp_data_q   <= core_codeout;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        core_rst_n_q <= 1'b0;
                        state_q      <= S_RESP;
                    end else if (to_last) begin
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        core_rst_n_q <= 1'b0;
                        state_q      <= S_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                S_RESP: begin
                    core_rst_n_q <= 1'b0;
                    if (rsp_accept) begin
                        rsp_valid_q <= 1'b0;
                        frames_q    <= frames_d;
                        if (rsp_err_q) begin
                            err_cnt_q <= err_cnt_d;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_rst_n_q <= 1'b0;
                    rsp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign core_codein = core_codein_q;
    assign core_states = core_states_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign frames_done = frames_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_viterbi_frame_ctrl
//
// Bench for viterbi_frame_ctrl with a stub decoder core. The stub raises
// finish fin_at cycles after core_rst_n rises and returns stub_out.
// Expected responses are queued at grant time and compared on acceptance.
// ---------------------------------------------------------------------------
module tb_viterbi_frame_ctrl;

    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int LENIN   = 10;
    localparam int LENOUT  = 5;
    localparam int STW     = 16;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*LENIN-1:0] req_code;
    logic [NREQ-1:0]       req_ready;
    logic [STW-1:0]        cfg_states;
    logic                  core_rst_n;
    logic [LENIN-1:0]      core_codein;
    logic [STW-1:0]        core_states;
    logic [LENOUT-1:0]     core_codeout;
    logic                  core_finish;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LENOUT-1:0]     rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;
    logic                  busy;
    logic [15:0]           frames_done;
    logic [7:0]            err_count;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .NREQ(NREQ), .IDW(IDW), .LENIN(LENIN), .LENOUT(LENOUT),
        .STW(STW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
        .cfg_states(cfg_states),
        .core_rst_n(core_rst_n), .core_codein(core_codein), .core_states(core_states),
        .core_codeout(core_codeout), .core_finish(core_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
        .frames_done(frames_done), .err_count(err_count)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus sources ----------------
    logic [15:0]       fin_at   = 16'hFFFF;
    logic [LENOUT-1:0] stub_out = '0;
    logic [15:0]       stub_cnt = '0;
    logic [LENIN-1:0]  code_w [NREQ];
    int                pend   [NREQ];
    logic [NREQ-1:0]   gnt_seen = '0;

    always @(posedge clk) stub_cnt <= core_rst_n ? stub_cnt + 16'd1 : 16'd0;
    assign core_finish  = core_rst_n && (stub_cnt >= fin_at);
    assign core_codeout = stub_out;

    always_comb begin
        req_valid = '0;
        req_code  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]              = (pend[i] > 0);
            req_code[i*LENIN +: LENIN] = code_w[i];
        end
    end

    // Requester side: a consumed word advances to the requester's next word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_seen[i] && pend[i] > 0) begin
                    pend[i]--;
                    code_w[i] = code_w[i] + 10'h02B;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [LENOUT-1:0] data;
        logic              err;
        logic [LENIN-1:0]  code;
        logic [STW-1:0]    states;
        logic [31:0]       lat;
        logic [31:0]       gcyc;
    } exp_t;

    exp_t          sb [$];
    int            grant_log [$];
    int            cyc = 0;
    int            model_rr = NREQ - 1;
    int            frames_exp = 0;
    int            errs_exp = 0;
    logic          prev_valid = 1'b0;
    logic          prev_acc = 1'b0;
    logic          core_chk = 1'b0;
    exp_t          last_e;
    logic [LENOUT-1:0] h_data;
    logic [IDW-1:0]    h_id;
    logic              h_err;

    always @(negedge clk) begin
        exp_t e;
        int   g;
        cyc++;
        gnt_seen = '0;
        if (!rst) begin
            sb.delete();
            model_rr   = NREQ - 1;
            frames_exp = 0;
            errs_exp   = 0;
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            core_chk   = 1'b0;
        end else begin
            if (!busy && (req_valid != '0) && (req_ready == '0))
                check_val("grant_missing", {31'b0, |req_ready}, 32'd1);
            if (req_ready != '0) begin
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && req_valid[(model_rr + k) % NREQ]) g = (model_rr + k) % NREQ;
                end
                if (g < 0) g = 0;
                check_val("grant_onehot", req_ready, 32'd1 << g);
                check_val("core_rst_n_at_grant", core_rst_n, 0);
                gnt_seen = req_ready;
                grant_log.push_back(g);
                model_rr = g;
                e.id     = IDW'(g);
                e.err    = (fin_at >= 16'(TIMEOUT));
                e.data   = e.err ? '0 : stub_out;
                e.code   = req_code[g*LENIN +: LENIN];
                e.states = cfg_states;
                e.lat    = 2 + (e.err ? TIMEOUT : (int'(fin_at) + 1));
                e.gcyc   = cyc;
                sb.push_back(e);
                last_e   = e;
                core_chk = 1'b1;
            end
            if (core_chk && core_rst_n) begin
                check_val("core_codein", core_codein, last_e.code);
                check_val("core_states", core_states, last_e.states);
                core_chk = 1'b0;
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) check_val("rsp_unexpected", sb.size(), 1);
                else check_val("latency", cyc - sb[0].gcyc, sb[0].lat);
            end
            if (rsp_valid && prev_valid && !prev_acc) begin
                check_val("hold_data", rsp_data, h_data);
                check_val("hold_id", rsp_id, h_id);
                check_val("hold_err", rsp_err, h_err);
            end
            if (rsp_valid) begin
                check_val("ready_in_resp", req_ready, 0);
                h_data = rsp_data;
                h_id   = rsp_id;
                h_err  = rsp_err;
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check_val("rsp_id", rsp_id, e.id);
                check_val("rsp_data", rsp_data, e.data);
                check_val("rsp_err", rsp_err, e.err);
                check_val("frames_before", frames_done, frames_exp);
                check_val("errs_before", err_count, errs_exp);
                frames_exp++;
                if (e.err && errs_exp < 255) errs_exp++;
            end
            prev_acc   = rsp_valid && rsp_ready;
            prev_valid = rsp_valid;
        end
    end

    // ---------------- main sequence ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        bit done = 0;
        for (int i = 0; i < maxc && !done; i++) begin
            tick(1);
            if (sb.size() == 0 && !busy && !rsp_valid && pend[0] == 0 && pend[1] == 0) done = 1;
        end
        if (!done) check_val({tag, "_drain_timeout"}, sb.size() + pend[0] + pend[1], 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_core_rst_n"}, core_rst_n, 0);
        check_val({tag, "_core_codein"}, core_codein, 0);
        check_val({tag, "_core_states"}, core_states, 0);
        check_val({tag, "_rsp_valid"}, rsp_valid, 0);
        check_val({tag, "_rsp_data"}, rsp_data, 0);
        check_val({tag, "_rsp_id"}, rsp_id, 0);
        check_val({tag, "_rsp_err"}, rsp_err, 0);
        check_val({tag, "_req_ready"}, req_ready, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_frames"}, frames_done, 0);
        check_val({tag, "_errs"}, err_count, 0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i]   = 0;
            code_w[i] = '0;
        end
        rsp_ready  = 1'b1;
        cfg_states = '0;
        #1;
        tick(3);
        check_reset_vals("por");
        rst = 1'b1;
        tick(2);

        // Single frame on requester 0
        code_w[0]  = 10'h385;
        cfg_states = 16'hB4E1;
        stub_out   = 5'b10110;
        fin_at     = 16'd10;
        grant_log.delete();
        pend[0]    = 1;
        wait_drain("single", 200);
        check_val("single_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) check_val("single_gid", grant_log[0], 0);
        check_val("single_frames", frames_done, 1);
        check_val("single_codein", core_codein, 10'h385);
        check_val("single_states", core_states, 16'hB4E1);

        // Reset pulse in IDLE, then both requesters contend for 4 frames
        rst = 1'b0;
        tick(1);
        check_reset_vals("idle_rst");
        rst = 1'b1;
        tick(1);
        code_w[0]  = 10'h111;
        code_w[1]  = 10'h2A5;
        cfg_states = 16'h5A3C;
        stub_out   = 5'b01001;
        fin_at     = 16'd20;
        grant_log.delete();
        pend[0]    = 2;
        pend[1]    = 2;
        wait_drain("rr", 600);
        check_val("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check_val("rr_order", grant_log[i], i % 2);
        check_val("rr_frames", frames_done, 4);

        // Core never finishes: timeout
        fin_at   = 16'hFFFF;
        stub_out = 5'b11111;
        pend[0]  = 1;
        wait_drain("timeout", 300);
        check_val("timeout_errs", err_count, 1);
        check_val("timeout_frames", frames_done, 5);

        // Finish in the last RUN cycle coincides with the timeout
        fin_at   = 16'(TIMEOUT - 1);
        stub_out = 5'b00111;
        pend[1]  = 1;
        wait_drain("coincide", 300);
        check_val("coincide_errs", err_count, 1);
        check_val("coincide_frames", frames_done, 6);

        // Response back-pressure for 20 cycles
        rsp_ready = 1'b0;
        fin_at    = 16'd5;
        stub_out  = 5'b10011;
        pend[1]   = 1;
        begin
            int n = 0;
            while (!rsp_valid && n < 200) begin
                tick(1);
                n++;
            end
            if (!rsp_valid) check_val("hold_wait_timeout", rsp_valid, 1);
        end
        pend[0] = 1;
        tick(20);
        check_val("hold_valid", rsp_valid, 1);
        check_val("hold_frames", frames_done, 6);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        tick(1);
        check_val("hold_accept_once", rsp_valid, 0);
        check_val("hold_frames_after", frames_done, 7);
        wait_drain("hold", 300);
        check_val("hold_drain_frames", frames_done, 8);

        // Reset while RUN aborts the frame
        fin_at  = 16'hFFFF;
        pend[0] = 1;
        begin
            int n = 0;
            while (!core_rst_n && n < 50) begin
                tick(1);
                n++;
            end
            if (!core_rst_n) check_val("abort_wait_run", core_rst_n, 1);
        end
        tick(5);
        rst = 1'b0;
        #1;
        check_reset_vals("abort");
        tick(2);
        fin_at    = 16'd3;
        stub_out  = 5'b01110;
        grant_log.delete();
        pend[0]   = 1;
        pend[1]   = 1;
        rst       = 1'b1;
        wait_drain("post_abort", 300);
        check_val("post_abort_count", grant_log.size(), 2);
        if (grant_log.size() > 0) check_val("post_abort_first", grant_log[0], 0);
        if (grant_log.size() > 1) check_val("post_abort_second", grant_log[1], 1);
        check_val("post_abort_frames", frames_done, 2);
        check_val("post_abort_errs", err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
